if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage placed directly downstream of the PC register. Takes the current PC, fetches from instruction memory or I-cache over a variable-latency req/ack handshake, and loads the IF/ID pipeline register. Generates the fetch stall that freezes the PC on its CacheStall_i input. Absorbs hazard stalls and branch flushes.

## Interface
- NOP_INSTR, 32'h0000_0000, word loaded into IF/ID on flush/reset/idle
- PC_INC, 32'd4, increment added to the fetched PC for ifid_pc_o
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  CPU run enable; 0 forces IDLE synchronously
- pc_i  in  32  current PC (PC register output)
- stall_i  in  1  hazard stall: hold IF/ID
- flush_i  in  1  branch taken: squash IF/ID
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address; equals pc_i
- imem_ack_i  in  1  data valid this cycle; legal only while imem_req_o=1
- imem_data_i  in  32  fetched instruction
- fetch_stall_o  out  1  to PC CacheStall_i; PC must hold while 1
- ifid_pc_o  out  32  fetched PC + PC_INC
- ifid_instr_o  out  32  IF/ID instruction
- ifid_valid_o  out  1  IF/ID holds a real instruction

## Operation
- States: IDLE, FETCH, HOLD. Also has a 32-bit hold buffer and a 1-bit drop flag.
- Reset, or start_i=0 in any state:
  - State goes to IDLE; drop flag clears.
  - ifid_instr_o=NOP_INSTR, ifid_pc_o=0, ifid_valid_o=0.
  - imem_req_o=0, fetch_stall_o=0.
  - An outstanding request is abandoned; memory must tolerate this.
- IDLE: if start_i=1, go to FETCH on the next edge. No request is issued in IDLE.
- FETCH:
  - imem_req_o=1; imem_addr_o=pc_i, combinational. pc_i is stable because the PC is frozen.
  - fetch_stall_o = ~imem_ack_i.
  - On ack with flush_i=0, drop=0, stall_i=0: load IF/ID with imem_data_i, pc_i+PC_INC, valid=1. Stay in FETCH.
  - On ack with flush_i=0, drop=0, stall_i=1: capture data and PC into the hold buffer; IF/ID unchanged. Go to HOLD.
  - On ack with drop=1: discard the data and clear drop. IF/ID stays squashed. Stay in FETCH.
  - flush_i=1 with no ack: squash IF/ID (NOP_INSTR, valid=0) and set drop.
  - flush_i=1 with ack in the same cycle: squash IF/ID and discard the data; drop stays 0.
- HOLD:
  - imem_req_o=0, fetch_stall_o=1.
  - When stall_i=0: load IF/ID from the hold buffer, go to FETCH.
  - When flush_i=1: discard the buffer, squash IF/ID, go to FETCH.
- Priority: reset > start_i=0 > flush_i > stall_i > ack.
- While stall_i=1 and no flush, IF/ID holds its value (no clock-enable glitches).
- Redirect contract: the upstream branch mux keeps the target on pc_i until the cycle fetch_stall_o=0, when the PC loads it.
- ifid_pc_o arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.

## Timing
- Zero-wait memory (ack in the request cycle): one instruction per clock. Latency from PC update to IF/ID valid is 1 edge.
- N-cycle memory: fetch_stall_o is high for N-1 cycles. IF/ID loads on the edge ending the ack cycle.
- First request is one cycle after start_i rises (IDLE to FETCH).
- All IF/ID outputs are registered. imem_req_o, imem_addr_o and fetch_stall_o are combinational from state and inputs.
- Asynchronous reset takes effect immediately. Deassertion is synchronous to clk_i (external synchronizer).

## Configuration
- IF_PERF_CNT_EN defined:
  - Adds ports perf_fetch_cnt_o and perf_stall_cnt_o, each out, 32 bits.
  - perf_fetch_cnt_o increments on each IF/ID load with valid=1, including HOLD release.
  - perf_stall_cnt_o increments on each cycle with fetch_stall_o=1.
  - Both reset to 0 on rst_i or start_i=0 and wrap modulo 2^32.
- IF_PERF_CNT_EN undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Zero-wait stream: reset, start_i=1, ack always 1, PC 0,4,8. Required: IF/ID = (mem[0], 4, v1), (mem[4], 8, v1) on consecutive edges; fetch_stall_o never 1.
- 3-cycle memory: ack on the 3rd request cycle, pc_i=0x40. Required: fetch_stall_o=1 for 2 cycles; IF/ID = (data, 0x44, 1) after the ack edge.
- Stall during ack: stall_i=1 at ack. Required: IF/ID unchanged; HOLD with imem_req_o=0; 2 cycles later stall_i=0 gives IF/ID = buffered instr, next cycle requests pc_i.
- Flush mid-fetch: flush_i=1 one cycle before a late ack. Required: IF/ID = (NOP, -, 0); acked data dropped; fetch_stall_o=0 in the ack cycle; next fetch uses the redirected pc_i.
- Reset/start abort: assert rst_i=0 asynchronously during FETCH, then start_i=0 during HOLD. Required: all outputs 0/NOP immediately and on the next edge respectively; state IDLE.
- With IF_PERF_CNT_EN: run the 3-cycle memory scenario for 4 instructions. Required: perf_fetch_cnt_o=4, perf_stall_cnt_o=8.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC -> variable-latency imem handshake -> IF/ID register.
// Define IF_PERF_CNT_EN to add the fetch/stall performance counters.
`timescale 1ns/1ps
module if_fetch_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        fetch_stall_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_instr_o,
  output logic        ifid_valid_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_stall_cnt_o
`endif
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC    = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } ifid_t;

  state_t          r_state;
  state_t          w_state_nxt;
  ifid_t           r_ifid;
  ifid_t           w_ifid_nxt;
  logic            r_ifid_valid;
  logic            w_valid_nxt;
  logic            w_ifid_we;
  ifid_t           r_hold;
  ifid_t           w_hold_nxt;
  logic            r_drop;
  logic            w_drop_nxt;
  logic [XLEN-1:0] w_pc_inc;

  assign w_pc_inc    = XLEN'(pc_i + PC_INC);
  assign imem_addr_o = pc_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; start_i=0 overrides everything
  always_comb begin
    w_state_nxt = r_state;
    if (!start_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_FETCH;
        S_FETCH: if (!flush_i && !r_drop && stall_i && imem_ack_i) w_state_nxt = S_HOLD;
        S_HOLD:  if (flush_i || !stall_i) w_state_nxt = S_FETCH;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Handshake outputs and IF/ID / hold-buffer / drop-flag next values
  always_comb begin
    imem_req_o    = 1'b0;
    fetch_stall_o = 1'b0;
    w_ifid_nxt    = r_ifid;
    w_valid_nxt   = r_ifid_valid;
    w_ifid_we     = 1'b0;
    w_hold_nxt    = r_hold;
    w_drop_nxt    = r_drop;
    if (!start_i) begin
      w_ifid_nxt  = '{instr: NOP_INSTR, pc: '0};
      w_valid_nxt = 1'b0;
      w_ifid_we   = 1'b1;
      w_drop_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          imem_req_o    = 1'b1;
          fetch_stall_o = ~imem_ack_i;
          if (flush_i) begin
            // Data acked alongside the flush is simply ignored; a later ack must be dropped
            w_ifid_nxt.instr = NOP_INSTR;
            w_valid_nxt      = 1'b0;
            w_ifid_we        = 1'b1;
            w_drop_nxt       = ~imem_ack_i;
          end else if (imem_ack_i) begin
            if (r_drop) begin
              w_drop_nxt = 1'b0;
            end else if (stall_i) begin
              w_hold_nxt = '{instr: imem_data_i, pc: w_pc_inc};
            end else begin
              w_ifid_nxt  = '{instr: imem_data_i, pc: w_pc_inc};
              w_valid_nxt = 1'b1;
              w_ifid_we   = 1'b1;
            end
          end
        end
        S_HOLD: begin
          fetch_stall_o = 1'b1;
          if (flush_i) begin
            w_ifid_nxt.instr = NOP_INSTR;
            w_valid_nxt      = 1'b0;
            w_ifid_we        = 1'b1;
          end else if (!stall_i) begin
            w_ifid_nxt  = r_hold;
            w_valid_nxt = 1'b1;
            w_ifid_we   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // IF/ID register, hold buffer and drop flag; IF/ID only written on an explicit load/squash
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ifid       <= '{instr: NOP_INSTR, pc: '0};
      r_ifid_valid <= 1'b0;
      r_hold       <= '0;
      r_drop       <= 1'b0;
    end else begin
      if (w_ifid_we) begin
        r_ifid       <= w_ifid_nxt;
        r_ifid_valid <= w_valid_nxt;
      end
      r_hold <= w_hold_nxt;
      r_drop <= w_drop_nxt;
    end
  end

  assign ifid_instr_o = r_ifid.instr;
  assign ifid_pc_o    = r_ifid.pc;
  assign ifid_valid_o = r_ifid_valid;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  // Valid IF/ID loads and stalled cycles, cleared whenever the CPU is stopped
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else if (!start_i) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_ifid_we && w_valid_nxt) r_perf_fetch <= 32'(r_perf_fetch + 32'd1);
      if (fetch_stall_o)            r_perf_stall <= 32'(r_perf_stall + 32'd1);
    end
  end

  assign perf_fetch_cnt_o = r_perf_fetch;
  assign perf_stall_cnt_o = r_perf_stall;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios with a load scoreboard.
`timescale 1ns/1ps
module tb_if_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = '0;
  logic        fetch_stall_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_instr_o;
  logic        ifid_valid_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_o;
  logic [31:0] perf_stall_cnt_o;
`endif

  if_fetch_unit dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .pc_i         (pc_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_data_i  (imem_data_i),
    .fetch_stall_o(fetch_stall_o),
    .ifid_pc_o    (ifid_pc_o),
    .ifid_instr_o (ifid_instr_o),
    .ifid_valid_o (ifid_valid_o)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt_o(perf_fetch_cnt_o),
    .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sb_pop_check(input string tag);
    exp_t e;
    check_eq({tag, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_eq({tag, "_instr"}, ifid_instr_o, e.instr);
      check_eq({tag, "_pc"},    ifid_pc_o,    e.pc);
      check_eq({tag, "_valid"}, 32'(ifid_valid_o), 32'd1);
    end
  endtask

  task automatic check_squashed(input string tag);
    check_eq({tag, "_instr"}, ifid_instr_o, 32'h0);
    check_eq({tag, "_valid"}, 32'(ifid_valid_o), 32'd0);
  endtask

  // Memory answers on the lat-th request cycle; the load is expected on that edge
  task automatic mem_fetch(input logic [31:0] addr, input int lat, input string tag);
    pc_i    = addr;
    stall_i = 1'b0;
    flush_i = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      imem_ack_i  = (c == lat);
      imem_data_i = (c == lat) ? mem_word(addr) : 32'hDEAD_BEEF;
      #1;
      check_eq({tag, "_req"},   32'(imem_req_o), 32'd1);
      check_eq({tag, "_addr"},  imem_addr_o, addr);
      check_eq({tag, "_stall"}, 32'(fetch_stall_o), (c == lat) ? 32'd0 : 32'd1);
      if (c == lat) sb_q.push_back('{instr: mem_word(addr), pc: 32'(addr + 32'd4)});
      tick();
    end
    imem_ack_i = 1'b0;
    sb_pop_check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    #2 rst_i = 1'b0;
    #2;
    check_eq("rst_instr", ifid_instr_o, 32'h0);
    check_eq("rst_pc",    ifid_pc_o,    32'h0);
    check_eq("rst_valid", 32'(ifid_valid_o),  32'd0);
    check_eq("rst_req",   32'(imem_req_o),    32'd0);
    check_eq("rst_stall", 32'(fetch_stall_o), 32'd0);
    tick();
    rst_i = 1'b1;
    tick();
    start_i = 1'b1;
    #1;
    check_eq("idle_req", 32'(imem_req_o), 32'd0);
    tick();

    // Zero-wait stream, including the 32-bit PC wrap
    mem_fetch(32'h0, 1, "zw0");
    mem_fetch(32'h4, 1, "zw4");
    mem_fetch(32'h8, 1, "zw8");
    mem_fetch(32'hFFFF_FFFC, 1, "zwwrap");

    // 3-cycle memory
    mem_fetch(32'h40, 3, "lat3");

    // Hazard stall coincident with the ack
    pc_i = 32'h80; imem_ack_i = 1'b1; imem_data_i = mem_word(32'h80); stall_i = 1'b1;
    #1;
    check_eq("hold_ack_stall", 32'(fetch_stall_o), 32'd0);
    tick();
    imem_ack_i = 1'b0; pc_i = 32'h84;
    for (int k = 0; k < 2; k++) begin
      #1;
      check_eq("hold_req",   32'(imem_req_o),    32'd0);
      check_eq("hold_stall", 32'(fetch_stall_o), 32'd1);
      check_eq("hold_instr", ifid_instr_o, mem_word(32'h40));
      check_eq("hold_pc",    ifid_pc_o,    32'h44);
      if (k == 1) begin
        stall_i = 1'b0;
        sb_q.push_back('{instr: mem_word(32'h80), pc: 32'h84});
      end
      tick();
    end
    sb_pop_check("hold_rel");
    check_eq("hold_refetch_req",  32'(imem_req_o), 32'd1);
    check_eq("hold_refetch_addr", imem_addr_o, 32'h84);
    mem_fetch(32'h84, 1, "after_hold");

    // Flush one cycle before a late ack
    pc_i = 32'h100; imem_ack_i = 1'b0;
    tick();
    flush_i = 1'b1; pc_i = 32'h200;
    #1;
    check_eq("flush_stall", 32'(fetch_stall_o), 32'd1);
    tick();
    flush_i = 1'b0;
    check_squashed("flush_sq");
    imem_ack_i = 1'b1; imem_data_i = mem_word(32'h100);
    #1;
    check_eq("drop_ack_stall", 32'(fetch_stall_o), 32'd0);
    tick();
    imem_ack_i = 1'b0;
    check_squashed("drop_sq");
    mem_fetch(32'h200, 2, "redirect");

    // Flush together with ack: data discarded, no drop pending afterwards
    pc_i = 32'h300; imem_ack_i = 1'b1; imem_data_i = mem_word(32'h300); flush_i = 1'b1;
    tick();
    imem_ack_i = 1'b0; flush_i = 1'b0;
    check_squashed("flush_ack_sq");
    mem_fetch(32'h304, 1, "flush_ack_next");

    // Asynchronous reset during a fetch
    pc_i = 32'h400; imem_ack_i = 1'b0;
    #1;
    check_eq("abort_pre_req", 32'(imem_req_o), 32'd1);
    #2 rst_i = 1'b0;
    #1;
    check_eq("arst_req",   32'(imem_req_o),    32'd0);
    check_eq("arst_stall", 32'(fetch_stall_o), 32'd0);
    check_eq("arst_instr", ifid_instr_o, 32'h0);
    check_eq("arst_pc",    ifid_pc_o,    32'h0);
    check_eq("arst_valid", 32'(ifid_valid_o), 32'd0);
    tick();
    rst_i = 1'b1;
    #1;
    check_eq("arst_idle_req", 32'(imem_req_o), 32'd0);
    tick();
    mem_fetch(32'h500, 1, "post_rst");

    // start_i=0 while in HOLD
    pc_i = 32'h504; imem_ack_i = 1'b1; imem_data_i = mem_word(32'h504); stall_i = 1'b1;
    tick();
    imem_ack_i = 1'b0;
    #1;
    check_eq("stop_hold_req", 32'(imem_req_o), 32'd0);
    check_eq("stop_hold_stall", 32'(fetch_stall_o), 32'd1);
    start_i = 1'b0;
    #1;
    check_eq("stop_req",   32'(imem_req_o),    32'd0);
    check_eq("stop_stall", 32'(fetch_stall_o), 32'd0);
    check_eq("stop_instr_pre", ifid_instr_o, mem_word(32'h500));
    tick();
    check_eq("stop_instr", ifid_instr_o, 32'h0);
    check_eq("stop_pc",    ifid_pc_o,    32'h0);
    check_eq("stop_valid", 32'(ifid_valid_o), 32'd0);
`ifdef IF_PERF_CNT_EN
    check_eq("perf_clr_fetch", perf_fetch_cnt_o, 32'd0);
    check_eq("perf_clr_stall", perf_stall_cnt_o, 32'd0);
`endif
    stall_i = 1'b0; start_i = 1'b1;
    #1;
    check_eq("restart_idle_req", 32'(imem_req_o), 32'd0);
    tick();
    check_eq("restart_no_buf", 32'(ifid_valid_o), 32'd0);
    check_eq("restart_req",    32'(imem_req_o),   32'd1);

    // Four instructions from 3-cycle memory
    for (int i = 0; i < 4; i++) mem_fetch(32'h600 + 32'(i * 4), 3, "perf_run");
`ifdef IF_PERF_CNT_EN
    check_eq("perf_fetch", perf_fetch_cnt_o, 32'd4);
    check_eq("perf_stall", perf_stall_cnt_o, 32'd8);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
